fx_seq_ctrl: RTL and testbench

//  Register-mapped sequencer on the FX host bus. Decodes host writes into control registers and

---
 rtl/fx_ctrl_pkg.sv | 35 +++
 rtl/fx_seq_fsm.sv | 90 +++++++++
 rtl/fx_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_fx_seq_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fx_ctrl_pkg.sv
// Shared constants for the FX-mapped burst sequencer: widths, register map, status bits, FSM encoding.
package fx_ctrl_pkg;

    localparam int unsigned FX_ADDR_W = 22;
    localparam int unsigned FX_DATA_W = 8;
    localparam int unsigned FX_OFF_W  = 3;
    localparam int unsigned SEQ_CNT_W = 16;
    localparam int unsigned SEQ_DLY_W = 8;

    // Register offsets within the 8-byte window
    localparam logic [FX_OFF_W-1:0] OFF_ID     = 3'd0;
    localparam logic [FX_OFF_W-1:0] OFF_CTRL   = 3'd1;
    localparam logic [FX_OFF_W-1:0] OFF_STATUS = 3'd2;
    localparam logic [FX_OFF_W-1:0] OFF_LEN_L  = 3'd3;
    localparam logic [FX_OFF_W-1:0] OFF_LEN_H  = 3'd4;
    localparam logic [FX_OFF_W-1:0] OFF_DLY    = 3'd5;
    localparam logic [FX_OFF_W-1:0] OFF_CNT_L  = 3'd6;
    localparam logic [FX_OFF_W-1:0] OFF_CNT_H  = 3'd7;

    // CTRL and STATUS bit positions
    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_ABORT    = 1;
    localparam int unsigned ST_BUSY       = 0;
    localparam int unsigned ST_DONE       = 1;
    localparam int unsigned ST_ABORTED    = 2;
    localparam int unsigned ST_START_IGN  = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_DELAY = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fx_seq_fsm.sv
// Burst sequencer: pre-delay countdown, RUN for len cycles, one-cycle DONE; abortable.
module fx_seq_fsm
    import fx_ctrl_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SEQ_CNT_W-1:0] len,
    input  logic [SEQ_DLY_W-1:0] dly,
    output logic                 run_en,
    output logic                 seq_busy,
    output logic                 done_pls,
    output logic                 aborted,
    output logic [SEQ_CNT_W-1:0] cnt
);

    seq_state_e           state_q, state_d;
    logic [SEQ_DLY_W-1:0] dcnt_q, dcnt_d;
    logic [SEQ_CNT_W-1:0] cnt_d;
    logic                 aborted_d;

    // State, counters and registered output decodes of the next state
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEQ_IDLE;
            dcnt_q   <= '0;
            cnt      <= '0;
            run_en   <= 1'b0;
            seq_busy <= 1'b0;
            done_pls <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            cnt      <= cnt_d;
            run_en   <= (state_d == SEQ_RUN);
            seq_busy <= (state_d == SEQ_DELAY) || (state_d == SEQ_RUN);
            done_pls <= (state_d == SEQ_DONE);
            aborted  <= aborted_d;
        end
    end

    // Next-state and counter update; abort takes priority over everything else
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        cnt_d     = cnt;
        aborted_d = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (abort) begin
                    aborted_d = start;
                end else if (start) begin
                    state_d = SEQ_DELAY;
                    dcnt_d  = dly;
                    cnt_d   = len;
                end
            end
            SEQ_DELAY: begin
                if (abort) begin
                    state_d   = SEQ_IDLE;
                    aborted_d = 1'b1;
                end else if (dcnt_q == '0) begin
                    state_d = (cnt == '0) ? SEQ_DONE : SEQ_RUN;
                end else begin
                    dcnt_d = dcnt_q - SEQ_DLY_W'(1);
                end
            end
            SEQ_RUN: begin
                if (abort) begin
                    state_d   = SEQ_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    cnt_d = cnt - SEQ_CNT_W'(1);
                    if (cnt == SEQ_CNT_W'(1)) begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fx_seq_ctrl.sv
// FX-bus register front end for the burst sequencer: decode, register bank, sticky status, read mux.
module fx_seq_ctrl
    import fx_ctrl_pkg::*;
#(
    parameter logic [FX_ADDR_W-1:0] BASE_ADDR = 22'h000000,
    parameter logic [FX_DATA_W-1:0] ID_VAL    = 8'hA5
)
(
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 fx_wr,
    input  logic [FX_ADDR_W-1:0] fx_waddr,
    input  logic [FX_DATA_W-1:0] fx_data,
    input  logic                 fx_rd,
    input  logic [FX_ADDR_W-1:0] fx_raddr,
    output logic [FX_DATA_W-1:0] fx_q,
    output logic                 run_en,
    output logic                 seq_busy,
    output logic                 done_pls
);

    logic                 wr_hit_c, rd_hit_c;
    logic [FX_OFF_W-1:0]  wr_off_c, rd_off_c;
    logic [FX_DATA_W-1:0] len_l_q, len_h_q, dly_q;
    logic                 start_q, abort_q;
    logic                 done_st_q, abort_st_q, ign_st_q;
    logic                 status_clr_c, ign_set_c;
    logic                 aborted;
    logic [SEQ_CNT_W-1:0] cnt;
    logic [FX_DATA_W-1:0] status_c, rd_data_c;

    assign wr_hit_c = fx_wr && (fx_waddr[FX_ADDR_W-1:FX_OFF_W] == BASE_ADDR[FX_ADDR_W-1:FX_OFF_W]);
    assign rd_hit_c = fx_rd && (fx_raddr[FX_ADDR_W-1:FX_OFF_W] == BASE_ADDR[FX_ADDR_W-1:FX_OFF_W]);
    assign wr_off_c = fx_waddr[FX_OFF_W-1:0];
    assign rd_off_c = fx_raddr[FX_OFF_W-1:0];

    assign status_clr_c = rd_hit_c && (rd_off_c == OFF_STATUS);
    // A start that lands while the sequencer is mid-burst or finishing is dropped and flagged
    assign ign_set_c    = start_q && (seq_busy || done_pls);

    // Writable registers and the self-clearing CTRL strobes
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            len_l_q <= '0;
            len_h_q <= '0;
            dly_q   <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            start_q <= wr_hit_c && (wr_off_c == OFF_CTRL) && fx_data[CTRL_START];
            abort_q <= wr_hit_c && (wr_off_c == OFF_CTRL) && fx_data[CTRL_ABORT];
            if (wr_hit_c) begin
                unique case (wr_off_c)
                    OFF_LEN_L: len_l_q <= fx_data;
                    OFF_LEN_H: len_h_q <= fx_data;
                    OFF_DLY:   dly_q   <= fx_data;
                    default:   ;
                endcase
            end
        end
    end

    // Sticky status flags: cleared by a STATUS read, a same-cycle set wins
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            done_st_q  <= 1'b0;
            abort_st_q <= 1'b0;
            ign_st_q   <= 1'b0;
        end else begin
            done_st_q  <= done_pls  || (done_st_q  && !status_clr_c);
            abort_st_q <= aborted   || (abort_st_q && !status_clr_c);
            ign_st_q   <= ign_set_c || (ign_st_q   && !status_clr_c);
        end
    end

    // STATUS byte assembly
    always_comb begin
        status_c               = '0;
        status_c[ST_BUSY]      = seq_busy;
        status_c[ST_DONE]      = done_st_q;
        status_c[ST_ABORTED]   = abort_st_q;
        status_c[ST_START_IGN] = ign_st_q;
    end

    // Read mux over the register window
    always_comb begin
        rd_data_c = '0;
        unique case (rd_off_c)
            OFF_ID:     rd_data_c = ID_VAL;
            OFF_CTRL:   rd_data_c = '0;
            OFF_STATUS: rd_data_c = status_c;
            OFF_LEN_L:  rd_data_c = len_l_q;
            OFF_LEN_H:  rd_data_c = len_h_q;
            OFF_DLY:    rd_data_c = dly_q;
            OFF_CNT_L:  rd_data_c = cnt[FX_DATA_W-1:0];
            OFF_CNT_H:  rd_data_c = cnt[SEQ_CNT_W-1:FX_DATA_W];
            default:    rd_data_c = '0;
        endcase
    end

    // Read data register: one-cycle latency, holds between reads
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fx_q <= '0;
        end else if (fx_rd) begin
            fx_q <= rd_hit_c ? rd_data_c : '0;
        end
    end

    fx_seq_fsm u_fsm (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .start    (start_q),
        .abort    (abort_q),
        .len      ({len_h_q, len_l_q}),
        .dly      (dly_q),
        .run_en   (run_en),
        .seq_busy (seq_busy),
        .done_pls (done_pls),
        .aborted  (aborted),
        .cnt      (cnt)
    );

endmodule

// File: tb/tb_fx_seq_ctrl.sv
// Directed bench for fx_seq_ctrl: register access, burst timing, abort, restart, async reset.
module tb_fx_seq_ctrl;
    import fx_ctrl_pkg::*;

    localparam logic [21:0] BASE  = 22'h012340;
    localparam logic [21:0] WRONG = 22'h012348;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        fx_wr, fx_rd;
    logic [21:0] fx_waddr, fx_raddr;
    logic [7:0]  fx_data;
    logic [7:0]  fx_q;
    logic        run_en, seq_busy, done_pls;

    int errors = 0;
    int checks = 0;
    int run_cnt = 0;
    int done_cnt = 0;
    int run_base, done_base;
    logic [7:0] q;

    fx_seq_ctrl #(.BASE_ADDR(BASE), .ID_VAL(8'hA5)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .fx_wr    (fx_wr),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q),
        .run_en   (run_en),
        .seq_busy (seq_busy),
        .done_pls (done_pls)
    );

    always #5 clk_sys = ~clk_sys;

    // Tally output activity at the falling edge
    always @(negedge clk_sys) begin
        if (run_en)   run_cnt  = run_cnt + 1;
        if (done_pls) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_a(input logic [21:0] addr, input logic [7:0] data);
        fx_waddr = addr;
        fx_data  = data;
        fx_wr    = 1'b1;
        @(posedge clk_sys);
        #1;
        fx_wr    = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] data);
        wr_a(BASE + 22'(off), data);
    endtask

    task automatic rd_a(input logic [21:0] addr, output logic [7:0] data);
        fx_raddr = addr;
        fx_rd    = 1'b1;
        @(posedge clk_sys);
        #1;
        fx_rd    = 1'b0;
        data     = fx_q;
    endtask

    task automatic rd(input logic [2:0] off, output logic [7:0] data);
        rd_a(BASE + 22'(off), data);
    endtask

    initial begin
        rst_n = 1'b0; fx_wr = 1'b0; fx_rd = 1'b0;
        fx_waddr = '0; fx_raddr = '0; fx_data = '0;
        tick(2);
        chk("rst_fx_q", 32'(fx_q), 32'h00);
        chk("rst_run_en", 32'(run_en), 32'h0);
        chk("rst_busy", 32'(seq_busy), 32'h0);
        chk("rst_done", 32'(done_pls), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // 1: ID/STATUS reads, hold, foreign base, same-cycle rd/wr
        rd(OFF_ID, q);      chk("t1_id", 32'(q), 32'hA5);
        tick(1);            chk("t1_hold", 32'(fx_q), 32'hA5);
        rd(OFF_STATUS, q);  chk("t1_status", 32'(q), 32'h00);
        rd_a(WRONG, q);     chk("t1_wrong_base", 32'(q), 32'h00);
        fx_waddr = BASE + 22'(OFF_LEN_L); fx_data = 8'h33; fx_wr = 1'b1;
        fx_raddr = BASE + 22'(OFF_LEN_L); fx_rd = 1'b1;
        tick(1);
        fx_wr = 1'b0; fx_rd = 1'b0;
        chk("t1_rdwr_old", 32'(fx_q), 32'h00);
        rd(OFF_LEN_L, q);   chk("t1_len_l", 32'(q), 32'h33);
        wr_a(WRONG + 22'(OFF_LEN_L), 8'h77);
        rd(OFF_LEN_L, q);   chk("t1_wr_foreign", 32'(q), 32'h33);
        rd(OFF_CTRL, q);    chk("t1_ctrl_rd", 32'(q), 32'h00);

        // 2: LEN=5, DLY=3 -> run_en on edges 5..9 after the start write, done on edge 10
        wr(OFF_LEN_L, 8'h05);
        wr(OFF_LEN_H, 8'h00);
        wr(OFF_DLY, 8'h03);
        wr(OFF_CTRL, 8'h01);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            chk("t2_run_en", 32'(run_en), 32'((k >= 5) && (k <= 9)));
            chk("t2_done", 32'(done_pls), 32'(k == 10));
        end
        rd(OFF_STATUS, q);  chk("t2_status", 32'(q), 32'h02);
        rd(OFF_STATUS, q);  chk("t2_status_clr", 32'(q), 32'h00);

        // 3: LEN=0x100, abort after 10 RUN decrements
        wr(OFF_DLY, 8'h00);
        wr(OFF_LEN_L, 8'h00);
        wr(OFF_LEN_H, 8'h01);
        done_base = done_cnt;
        wr(OFF_CTRL, 8'h01);
        tick(2);            chk("t3_run_start", 32'(run_en), 32'h1);
        tick(9);
        wr(OFF_CTRL, 8'h02);
        chk("t3_run_still", 32'(run_en), 32'h1);
        tick(1);
        chk("t3_run_drop", 32'(run_en), 32'h0);
        chk("t3_busy_drop", 32'(seq_busy), 32'h0);
        tick(3);
        chk("t3_no_done", 32'(done_cnt - done_base), 32'h0);
        rd(OFF_STATUS, q);  chk("t3_status", 32'(q), 32'h04);
        rd(OFF_CNT_L, q);   chk("t3_cnt_l", 32'(q), 32'hF6);
        rd(OFF_CNT_H, q);   chk("t3_cnt_h", 32'(q), 32'h00);

        // 4: restart and LEN write mid-burst do not disturb the running burst
        wr(OFF_LEN_L, 8'h04);
        wr(OFF_LEN_H, 8'h00);
        run_base = run_cnt; done_base = done_cnt;
        wr(OFF_CTRL, 8'h01);
        tick(1);
        wr(OFF_LEN_L, 8'h07);
        wr(OFF_CTRL, 8'h01);
        tick(10);
        chk("t4_len1", 32'(run_cnt - run_base), 32'd4);
        chk("t4_done1", 32'(done_cnt - done_base), 32'd1);
        rd(OFF_STATUS, q);  chk("t4_status", 32'(q), 32'h0A);
        run_base = run_cnt; done_base = done_cnt;
        wr(OFF_CTRL, 8'h01);
        tick(15);
        chk("t4_len2", 32'(run_cnt - run_base), 32'd7);
        chk("t4_done2", 32'(done_cnt - done_base), 32'd1);
        rd(OFF_STATUS, q);  chk("t4_status2", 32'(q), 32'h02);

        // 5: LEN=0, DLY=0 -> one DELAY cycle then DONE; start+abort stays idle
        wr(OFF_LEN_L, 8'h00);
        run_base = run_cnt;
        wr(OFF_CTRL, 8'h01);
        tick(1);
        chk("t5_busy", 32'(seq_busy), 32'h1);
        chk("t5_done_early", 32'(done_pls), 32'h0);
        tick(1);
        chk("t5_done", 32'(done_pls), 32'h1);
        tick(1);
        chk("t5_done_off", 32'(done_pls), 32'h0);
        chk("t5_no_run", 32'(run_cnt - run_base), 32'd0);
        wr(OFF_CTRL, 8'h03);
        tick(1);            chk("t5_idle_a", 32'(seq_busy), 32'h0);
        tick(2);            chk("t5_idle_b", 32'(seq_busy), 32'h0);
        rd(OFF_STATUS, q);  chk("t5_status", 32'(q), 32'h06);

        // 6: asynchronous reset in the middle of RUN
        wr(OFF_LEN_L, 8'h20);
        wr(OFF_DLY, 8'h02);
        wr(OFF_CTRL, 8'h01);
        tick(5);
        chk("t6_running", 32'(run_en), 32'h1);
        chk("t6_busy", 32'(seq_busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_run_async", 32'(run_en), 32'h0);
        chk("t6_busy_async", 32'(seq_busy), 32'h0);
        chk("t6_fx_q_async", 32'(fx_q), 32'h00);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        rd(OFF_ID, q);      chk("t6_id", 32'(q), 32'hA5);
        for (int o = 1; o < 8; o++) begin
            rd(3'(o), q);
            chk("t6_reg_zero", 32'(q), 32'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
